pipeline_id_stage: RTL and testbench
====================================

# pipeline_id_stage

Instruction Decode stage of the 5-stage RV64I pipeline. It consumes `pc_IF`/`instruction_IF` from the fetch stage and decodes the instruction. It reads the external register file, with write-back bypass, and builds the sign-extended immediate. Its ID/EX pipeline register feeds the execute stage. It also detects load-use hazards, inserts a bubble, and drives the stall request back to fetch.

## Interface
- `XLEN`, 64, datapath width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `pc_IF`  in  64  PC of `instruction_IF`.
- `instruction_IF`  in  32  fetched instruction.
- `stall_in`  in  1  downstream stall; hold the ID/EX register.
- `flush`  in  1  branch_taken from EX; discard the current decode.
- `rs1_addr`, `rs2_addr`  out  5  register file read addresses, combinational from `instruction_IF[19:15]` and `[24:20]`.
- `rs1_data`, `rs2_data`  in  64  register file read data.
- `wb_we`  in  1  write-back enable.
- `wb_rd`  in  5  write-back destination.
- `wb_data`  in  64  write-back value.
- `hazard_stall`  out  1  combinational load-use stall request to fetch.
- `valid_ID`  out  1  registered; the ID/EX slot holds a real instruction.
- `pc_ID`  out  64  registered PC.
- `rs1_val_ID`, `rs2_val_ID`  out  64  registered operands.
- `imm_ID`  out  64  registered sign-extended immediate.
- `rs1_ID`, `rs2_ID`, `rd_ID`  out  5  registered register indices.
- `alu_op_ID`  out  4  registered ALU operation.
- `funct3_ID`  out  3  registered funct3.
- `alu_src_a_ID`  out  2  operand A select: 0 = rs1, 1 = pc, 2 = zero.
- `alu_src_b_ID`  out  1  operand B select: 0 = rs2, 1 = imm.
- `word_op_ID`  out  1  W-suffix operation.
- `mem_read_ID`, `mem_write_ID`, `reg_write_ID`, `mem_to_reg_ID`, `branch_ID`, `jump_ID`  out  1  each, registered control bits.
- `illegal_ID`  out  1  registered; undecodable opcode.

## Operation
- Opcode classes:
  - LUI: src_a = zero, src_b = imm (U).
  - AUIPC: src_a = pc, src_b = imm (U).
  - JAL: jump, src_a = pc, imm (J).
  - JALR: jump, src_a = rs1, imm (I).
  - BRANCH: branch, alu_op SUB, imm (B).
  - LOAD: mem_read, mem_to_reg, reg_write, imm (I).
  - STORE: mem_write, imm (S).
  - OP-IMM and OP-IMM-32: reg_write, imm (I).
  - OP and OP-32: reg_write, src_b = rs2.
- `word_op_ID` = 1 for the -32 opcodes.
- `alu_op_ID` encoding:
  - OP / OP-32: `{funct7[5], funct3}`.
  - OP-IMM shifts (funct3 = 001 or 101): `{instr[30], funct3}`.
  - Other OP-IMM: `{0, funct3}`.
  - Address/PC classes: 0000 (ADD).
  - Branch: 1000 (SUB).
- Immediates are always sign-extended to 64 bits from `instr[31]`. U-type is `{instr[31:12], 12'b0}`, sign-extended.
- `instruction_IF == 0` (the fetch reset value) decodes as a bubble: `valid = 0`, `illegal = 0`.
- Any other unknown opcode gives a bubble with `illegal_ID = 1` for one slot.
- A bubble means `valid_ID` and every control bit are 0. Data fields are don't-care, but the implementation drives them to 0.
- `reg_write_ID` is forced to 0 when rd = 0.
- WB bypass: if `wb_we && wb_rd != 0 && wb_rd == rsN_addr`, use `wb_data` instead of `rsN_data`.
- Load-use: `hazard_stall = valid_ID & mem_read_ID & rd_ID != 0 & ((rd_ID == rs1_addr & uses_rs1) | (rd_ID == rs2_addr & uses_rs2)) & !flush`.
  - `uses_rs1`: all classes except LUI, AUIPC and JAL.
  - `uses_rs2`: BRANCH, STORE, OP and OP-32.
- ID/EX update priority each posedge:
  1. `flush`: load a bubble.
  2. `stall_in`: hold.
  3. `hazard_stall`: load a bubble.
  4. Otherwise load the decode.

## Timing
- All registered outputs reset to 0, including `valid_ID`.
- `rs*_addr` and `hazard_stall` are combinational.
- Latency: one cycle from `instruction_IF` to the `*_ID` outputs.
- During `hazard_stall`, fetch holds `instruction_IF`. The next cycle the dependent instruction decodes normally, which gives exactly one bubble.
- `flush` together with `stall_in`: flush wins and a bubble is loaded.
- `flush` together with a hazard: the hazard is masked, so there is no stall.
- Reset asserted mid-operation clears the register immediately (asynchronous). `hazard_stall` falls with `valid_ID`.

## Structure
- `pipeline_pkg` holds the opcode localparams, the ALU op codes (ADD = 0000, SUB = 1000) and the src_a encodings.
- Sub-module `pipeline_imm_gen` is purely combinational: instruction in, 64-bit immediate out.

## Test plan
- `addi x5, x0, -1` (0xFFF00293) → next cycle `imm_ID` = 0xFFFF_FFFF_FFFF_FFFF, `rd_ID` = 5, `reg_write_ID` = 1, `alu_src_b_ID` = 1.
- `ld x6, 0(x1)` followed by `add x7, x6, x2` → `hazard_stall` = 1 for one cycle and a bubble is inserted. The add then reaches `valid_ID` = 1 one cycle later.
- `wb_we` = 1, `wb_rd` = 3, `wb_data` = 0x1234, with `rs1_data` = 0 and `rs1_addr` = 3 → `rs1_val_ID` = 0x1234. With `wb_rd` = 0, `rs1_val_ID` follows `rs1_data` instead.
- `flush` during a valid `beq` → next cycle `valid_ID` = 0 and `branch_ID` = 0. Repeat with `stall_in` = 1 as well → the bubble still loads.
- Opcode 0x7F → `illegal_ID` = 1 and `valid_ID` = 0. `instruction_IF` = 0 → `illegal_ID` = 0 and `valid_ID` = 0.
- Assert `reset` mid-stream with `stall_in` = 1 → all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the instruction decode stage: RV64I opcode values,
//   ALU operation codes, operand-A select encodings and the packed control
//   bundle carried in the ID/EX register.
package pipeline_pkg;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   localparam logic [1:0] SRC_A_RS1  = 2'd0;
   localparam logic [1:0] SRC_A_PC   = 2'd1;
   localparam logic [1:0] SRC_A_ZERO = 2'd2;

   // An all-zero value of this bundle is a bubble.
   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [3:0] alu_op;
      logic [1:0] alu_src_a;
      logic       alu_src_b;
      logic       word_op;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
   } id_ctrl_t;

endpackage

// File: rtl/pipeline_imm_gen.sv
// pipeline_imm_gen
//   Combinational immediate generator. Selects the I/S/B/U/J format from
//   the opcode and sign-extends from instruction[31] to XLEN bits.
//   Ports:
//     instruction  in   32    instruction being decoded
//     imm          out  XLEN  sign-extended immediate (0 for R-type/unknown)
module pipeline_imm_gen
   import pipeline_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instruction,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm_w;
   logic        s;

   assign s = instruction[31];

   always_comb begin
      imm_w = '0;
      case (instruction[6:0])
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32:
            imm_w = {{20{s}}, instruction[31:20]};
         OPC_STORE:
            imm_w = {{20{s}}, instruction[31:25], instruction[11:7]};
         OPC_BRANCH:
            imm_w = {{19{s}}, s, instruction[7], instruction[30:25],
                     instruction[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm_w = {instruction[31:12], 12'b0};
         OPC_JAL:
            imm_w = {{11{s}}, s, instruction[19:12], instruction[20],
                     instruction[30:21], 1'b0};
         default:
            imm_w = '0;
      endcase
   end

   // every 32-bit form already carries instruction[31] in its MSB
   assign imm = {{(XLEN-32){imm_w[31]}}, imm_w};

endmodule

// File: rtl/pipeline_id_stage.sv
// pipeline_id_stage
//   Instruction decode stage of the RV64I pipeline: decodes instruction_IF,
//   reads the register file with write-back bypass, builds the immediate,
//   detects load-use hazards and holds the ID/EX pipeline register.
//   Ports:
//     clk, reset            clock, async active-high reset
//     pc_IF, instruction_IF fetch-stage PC and instruction
//     stall_in, flush       downstream hold / branch-taken discard
//     rs1_addr, rs2_addr    register file read addresses (combinational)
//     rs1_data, rs2_data    register file read data
//     wb_we, wb_rd, wb_data write-back port used for bypass
//     hazard_stall          load-use stall request to fetch (combinational)
//     *_ID                  registered ID/EX outputs
module pipeline_id_stage
   import pipeline_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_IF,
   input  logic [31:0]     instruction_IF,
   input  logic            stall_in,
   input  logic            flush,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            hazard_stall,
   output logic            valid_ID,
   output logic [XLEN-1:0] pc_ID,
   output logic [XLEN-1:0] rs1_val_ID,
   output logic [XLEN-1:0] rs2_val_ID,
   output logic [XLEN-1:0] imm_ID,
   output logic [4:0]      rs1_ID,
   output logic [4:0]      rs2_ID,
   output logic [4:0]      rd_ID,
   output logic [3:0]      alu_op_ID,
   output logic [2:0]      funct3_ID,
   output logic [1:0]      alu_src_a_ID,
   output logic            alu_src_b_ID,
   output logic            word_op_ID,
   output logic            mem_read_ID,
   output logic            mem_write_ID,
   output logic            reg_write_ID,
   output logic            mem_to_reg_ID,
   output logic            branch_ID,
   output logic            jump_ID,
   output logic            illegal_ID
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            is_shift;
   logic            uses_rs1;
   logic            uses_rs2;
   id_ctrl_t        dec;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   id_ctrl_t        ctrl_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] rs1_val_q;
   logic [XLEN-1:0] rs2_val_q;
   logic [XLEN-1:0] imm_q;

   logic            load_en;
   logic            load_bubble;

   assign opcode   = instruction_IF[6:0];
   assign funct3   = instruction_IF[14:12];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
   assign rs1_addr = instruction_IF[19:15];
   assign rs2_addr = instruction_IF[24:20];

   pipeline_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instruction (instruction_IF),
      .imm         (imm)
   );

   always_comb begin
      dec      = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      case (opcode)
         OPC_LUI: begin
            dec.valid     = 1'b1;
            dec.alu_src_a = SRC_A_ZERO;
            dec.alu_src_b = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            dec.valid     = 1'b1;
            dec.alu_src_a = SRC_A_PC;
            dec.alu_src_b = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_JAL: begin
            dec.valid     = 1'b1;
            dec.jump      = 1'b1;
            dec.alu_src_a = SRC_A_PC;
            dec.alu_src_b = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_JALR: begin
            dec.valid     = 1'b1;
            dec.jump      = 1'b1;
            dec.alu_src_b = 1'b1;
            dec.reg_write = 1'b1;
            uses_rs1      = 1'b1;
         end
         OPC_BRANCH: begin
            // ALU compares rs1 against rs2; the target adder uses imm_ID
            dec.valid  = 1'b1;
            dec.branch = 1'b1;
            dec.alu_op = ALU_SUB;
            uses_rs1   = 1'b1;
            uses_rs2   = 1'b1;
         end
         OPC_LOAD: begin
            dec.valid      = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.alu_src_b  = 1'b1;
            uses_rs1       = 1'b1;
         end
         OPC_STORE: begin
            dec.valid     = 1'b1;
            dec.mem_write = 1'b1;
            dec.alu_src_b = 1'b1;
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
         end
         OPC_OP_IMM, OPC_OP_IMM_32: begin
            dec.valid     = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src_b = 1'b1;
            dec.word_op   = (opcode == OPC_OP_IMM_32);
            // bit 30 only selects SRA/SRL on shifts; elsewhere it is imm data
            dec.alu_op    = {is_shift & instruction_IF[30], funct3};
            uses_rs1      = 1'b1;
         end
         OPC_OP, OPC_OP_32: begin
            dec.valid     = 1'b1;
            dec.reg_write = 1'b1;
            dec.word_op   = (opcode == OPC_OP_32);
            dec.alu_op    = {instruction_IF[30], funct3};
            uses_rs1      = 1'b1;
            uses_rs2      = 1'b1;
         end
         default: begin
            // all-zero is the fetch reset value and is a silent bubble
            dec.illegal = (instruction_IF != 32'd0);
         end
      endcase
      if (dec.valid) begin
         dec.rs1    = rs1_addr;
         dec.rs2    = rs2_addr;
         dec.rd     = instruction_IF[11:7];
         dec.funct3 = funct3;
      end
      if (dec.rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end
   end

   assign rs1_fwd = (wb_we && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rs1_data;
   assign rs2_fwd = (wb_we && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rs2_data;

   assign hazard_stall = ctrl_q.valid & ctrl_q.mem_read & (ctrl_q.rd != 5'd0) &
                         (((ctrl_q.rd == rs1_addr) & uses_rs1) |
                          ((ctrl_q.rd == rs2_addr) & uses_rs2)) & ~flush;

   // flush beats stall_in; stall_in beats a hazard bubble
   assign load_en     = flush | ~stall_in;
   assign load_bubble = flush | hazard_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q    <= '0;
         pc_q      <= '0;
         rs1_val_q <= '0;
         rs2_val_q <= '0;
         imm_q     <= '0;
      end else if (load_en) begin
         if (load_bubble || !dec.valid) begin
            ctrl_q    <= load_bubble ? '0 : dec;
            pc_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            imm_q     <= '0;
         end else begin
            ctrl_q    <= dec;
            pc_q      <= pc_IF;
            rs1_val_q <= rs1_fwd;
            rs2_val_q <= rs2_fwd;
            imm_q     <= imm;
         end
      end
   end

   assign valid_ID      = ctrl_q.valid;
   assign illegal_ID    = ctrl_q.illegal;
   assign pc_ID         = pc_q;
   assign rs1_val_ID    = rs1_val_q;
   assign rs2_val_ID    = rs2_val_q;
   assign imm_ID        = imm_q;
   assign rs1_ID        = ctrl_q.rs1;
   assign rs2_ID        = ctrl_q.rs2;
   assign rd_ID         = ctrl_q.rd;
   assign alu_op_ID     = ctrl_q.alu_op;
   assign funct3_ID     = ctrl_q.funct3;
   assign alu_src_a_ID  = ctrl_q.alu_src_a;
   assign alu_src_b_ID  = ctrl_q.alu_src_b;
   assign word_op_ID    = ctrl_q.word_op;
   assign mem_read_ID   = ctrl_q.mem_read;
   assign mem_write_ID  = ctrl_q.mem_write;
   assign reg_write_ID  = ctrl_q.reg_write;
   assign mem_to_reg_ID = ctrl_q.mem_to_reg;
   assign branch_ID     = ctrl_q.branch;
   assign jump_ID       = ctrl_q.jump;

endmodule

// File: tb/tb_pipeline_id_stage.sv
// tb_pipeline_id_stage
//   Directed bench for pipeline_id_stage. Each step drives one instruction
//   and pushes the expected ID/EX contents; after the next rising edge the
//   expectation is popped and compared field by field.
module tb_pipeline_id_stage;

   typedef struct packed {
      logic        valid;
      logic        illegal;
      logic [63:0] pc;
      logic [63:0] rs1v;
      logic [63:0] rs2v;
      logic [63:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic [2:0]  f3;
      logic [1:0]  src_a;
      logic        src_b;
      logic        word_op;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        mem_to_reg;
      logic        branch;
      logic        jump;
   } exp_t;

   localparam logic [63:0] R1 = 64'hAAAA_0000_0000_0001;
   localparam logic [63:0] R2 = 64'h0000_BBBB_0000_0002;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc_IF;
   logic [31:0] instruction_IF;
   logic        stall_in, flush;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [63:0] rs1_data, rs2_data;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        hazard_stall, valid_ID;
   logic [63:0] pc_ID, rs1_val_ID, rs2_val_ID, imm_ID;
   logic [4:0]  rs1_ID, rs2_ID, rd_ID;
   logic [3:0]  alu_op_ID;
   logic [2:0]  funct3_ID;
   logic [1:0]  alu_src_a_ID;
   logic        alu_src_b_ID, word_op_ID, mem_read_ID, mem_write_ID;
   logic        reg_write_ID, mem_to_reg_ID, branch_ID, jump_ID, illegal_ID;

   int    checks = 0;
   int    failures = 0;
   string cur;
   exp_t  sb_q[$];
   exp_t  e;

   always #5 clk = ~clk;

   pipeline_id_stage #(.XLEN(64)) dut (
      .clk(clk), .reset(reset), .pc_IF(pc_IF), .instruction_IF(instruction_IF),
      .stall_in(stall_in), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .hazard_stall(hazard_stall), .valid_ID(valid_ID),
      .pc_ID(pc_ID), .rs1_val_ID(rs1_val_ID), .rs2_val_ID(rs2_val_ID),
      .imm_ID(imm_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
      .alu_op_ID(alu_op_ID), .funct3_ID(funct3_ID), .alu_src_a_ID(alu_src_a_ID),
      .alu_src_b_ID(alu_src_b_ID), .word_op_ID(word_op_ID),
      .mem_read_ID(mem_read_ID), .mem_write_ID(mem_write_ID),
      .reg_write_ID(reg_write_ID), .mem_to_reg_ID(mem_to_reg_ID),
      .branch_ID(branch_ID), .jump_ID(jump_ID), .illegal_ID(illegal_ID)
   );

   task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s.%s observed=%h expected=%h", cur, tag, obs, expv);
      end
   endtask

   function automatic exp_t base(input logic [63:0] pc, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [2:0] f3);
      exp_t x;
      x       = '0;
      x.valid = 1'b1;
      x.pc    = pc;
      x.rs1   = rs1;
      x.rs2   = rs2;
      x.rd    = rd;
      x.f3    = f3;
      x.rs1v  = R1;
      x.rs2v  = R2;
      return x;
   endfunction

   task automatic drive(input string name, input logic [31:0] ins, input logic [63:0] pc,
                        input logic fl, input logic st, input exp_t ex);
      cur            = name;
      instruction_IF = ins;
      pc_IF          = pc;
      flush          = fl;
      stall_in       = st;
      sb_q.push_back(ex);
      #1;
   endtask

   task automatic tick();
      exp_t x;
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s.scoreboard observed=empty expected=entry", cur);
      end else begin
         x = sb_q.pop_front();
         cmp("valid",      64'(valid_ID),      64'(x.valid));
         cmp("illegal",    64'(illegal_ID),    64'(x.illegal));
         cmp("pc",         pc_ID,              x.pc);
         cmp("rs1_val",    rs1_val_ID,         x.rs1v);
         cmp("rs2_val",    rs2_val_ID,         x.rs2v);
         cmp("imm",        imm_ID,             x.imm);
         cmp("rs1",        64'(rs1_ID),        64'(x.rs1));
         cmp("rs2",        64'(rs2_ID),        64'(x.rs2));
         cmp("rd",         64'(rd_ID),         64'(x.rd));
         cmp("alu_op",     64'(alu_op_ID),     64'(x.alu_op));
         cmp("funct3",     64'(funct3_ID),     64'(x.f3));
         cmp("src_a",      64'(alu_src_a_ID),  64'(x.src_a));
         cmp("src_b",      64'(alu_src_b_ID),  64'(x.src_b));
         cmp("word_op",    64'(word_op_ID),    64'(x.word_op));
         cmp("mem_read",   64'(mem_read_ID),   64'(x.mem_read));
         cmp("mem_write",  64'(mem_write_ID),  64'(x.mem_write));
         cmp("reg_write",  64'(reg_write_ID),  64'(x.reg_write));
         cmp("mem_to_reg", 64'(mem_to_reg_ID), 64'(x.mem_to_reg));
         cmp("branch",     64'(branch_ID),     64'(x.branch));
         cmp("jump",       64'(jump_ID),       64'(x.jump));
      end
   endtask

   initial begin
      reset = 1'b1; pc_IF = '0; instruction_IF = '0; stall_in = 1'b0; flush = 1'b0;
      rs1_data = R1; rs2_data = R2; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      cur = "reset";
      repeat (2) @(posedge clk);
      #1;
      cmp("valid",   64'(valid_ID),     64'd0);
      cmp("illegal", 64'(illegal_ID),   64'd0);
      cmp("pc",      pc_ID,             64'd0);
      cmp("imm",     imm_ID,            64'd0);
      cmp("rw",      64'(reg_write_ID), 64'd0);
      cmp("hazard",  64'(hazard_stall), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // addi x5, x0, -1
      e = base(64'h100, 5'd0, 5'd31, 5'd5, 3'd0);
      e.imm = '1; e.src_b = 1'b1; e.reg_write = 1'b1;
      drive("addi_m1", 32'hFFF00293, 64'h100, 1'b0, 1'b0, e);
      cmp("rs1_addr", 64'(rs1_addr), 64'd0);
      cmp("rs2_addr", 64'(rs2_addr), 64'd31);
      tick();

      // ld x6, 0(x1)
      e = base(64'h104, 5'd1, 5'd0, 5'd6, 3'd3);
      e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.src_b = 1'b1;
      drive("ld", 32'h0000B303, 64'h104, 1'b0, 1'b0, e);
      cmp("hazard", 64'(hazard_stall), 64'd0);
      tick();

      // add x7, x6, x2 behind the load: one bubble, then the add
      e = '0;
      drive("add_hz", 32'h002303B3, 64'h108, 1'b0, 1'b0, e);
      cmp("hazard", 64'(hazard_stall), 64'd1);
      tick();
      e = base(64'h108, 5'd6, 5'd2, 5'd7, 3'd0);
      e.reg_write = 1'b1;
      drive("add_go", 32'h002303B3, 64'h108, 1'b0, 1'b0, e);
      cmp("hazard", 64'(hazard_stall), 64'd0);
      tick();

      // addi x8, x3, 5 with write-back to x3 in flight
      rs1_data = '0; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 64'h1234;
      e = base(64'h10C, 5'd3, 5'd5, 5'd8, 3'd0);
      e.rs1v = 64'h1234; e.imm = 64'd5; e.src_b = 1'b1; e.reg_write = 1'b1;
      drive("byp_rs1", 32'h00518413, 64'h10C, 1'b0, 1'b0, e);
      cmp("rs1_addr", 64'(rs1_addr), 64'd3);
      tick();

      // write-back to x0 never bypasses, even when reading x0
      rs1_data = 64'h55; wb_rd = 5'd0;
      e = base(64'h110, 5'd0, 5'd5, 5'd8, 3'd0);
      e.rs1v = 64'h55; e.imm = 64'd5; e.src_b = 1'b1; e.reg_write = 1'b1;
      drive("byp_x0", 32'h00500413, 64'h110, 1'b0, 1'b0, e);
      tick();

      // add x9, x4, x3 with bypass on rs2
      rs1_data = R1; wb_rd = 5'd3;
      e = base(64'h114, 5'd4, 5'd3, 5'd9, 3'd0);
      e.rs2v = 64'h1234; e.reg_write = 1'b1;
      drive("byp_rs2", 32'h003204B3, 64'h114, 1'b0, 1'b0, e);
      tick();
      wb_we = 1'b0; wb_rd = '0; wb_data = '0;

      // beq x1, x2, +8
      e = base(64'h118, 5'd1, 5'd2, 5'd8, 3'd0);
      e.branch = 1'b1; e.alu_op = 4'b1000; e.imm = 64'd8;
      drive("beq", 32'h00208463, 64'h118, 1'b0, 1'b0, e);
      tick();
      drive("beq_flush", 32'h00208463, 64'h118, 1'b1, 1'b0, '0);
      tick();
      drive("beq_again", 32'h00208463, 64'h118, 1'b0, 1'b0, e);
      tick();
      drive("beq_flush_stall", 32'h00208463, 64'h118, 1'b1, 1'b1, '0);
      tick();

      // lui x10, 0x80000 then hold it with stall_in
      e = base(64'h11C, 5'd0, 5'd0, 5'd10, 3'd0);
      e.imm = 64'hFFFF_FFFF_8000_0000; e.src_a = 2'd2; e.src_b = 1'b1; e.reg_write = 1'b1;
      drive("lui", 32'h80000537, 64'h11C, 1'b0, 1'b0, e);
      tick();
      drive("stall_hold", 32'hFFF00293, 64'h200, 1'b0, 1'b1, e);
      tick();

      // sw x2, -4(x1)
      e = base(64'h120, 5'd1, 5'd2, 5'd28, 3'd2);
      e.imm = 64'hFFFF_FFFF_FFFF_FFFC; e.mem_write = 1'b1; e.src_b = 1'b1;
      drive("sw", 32'hFE20AE23, 64'h120, 1'b0, 1'b0, e);
      tick();

      // jal x1, -8
      e = base(64'h124, 5'd31, 5'd25, 5'd1, 3'd7);
      e.imm = 64'hFFFF_FFFF_FFFF_FFF8; e.jump = 1'b1; e.src_a = 2'd1;
      e.src_b = 1'b1; e.reg_write = 1'b1;
      drive("jal", 32'hFF9FF0EF, 64'h124, 1'b0, 1'b0, e);
      tick();

      // addw / subw
      e = base(64'h128, 5'd1, 5'd2, 5'd11, 3'd0);
      e.word_op = 1'b1; e.reg_write = 1'b1;
      drive("addw", 32'h002085BB, 64'h128, 1'b0, 1'b0, e);
      tick();
      e.pc = 64'h12C; e.alu_op = 4'b1000;
      drive("subw", 32'h402085BB, 64'h12C, 1'b0, 1'b0, e);
      tick();

      // srai x12, x1, 3 keeps bit 30; xori with imm bit 10 set drops it
      e = base(64'h130, 5'd1, 5'd3, 5'd12, 3'd5);
      e.imm = 64'h403; e.alu_op = 4'b1101; e.src_b = 1'b1; e.reg_write = 1'b1;
      drive("srai", 32'h4030D613, 64'h130, 1'b0, 1'b0, e);
      tick();
      e = base(64'h134, 5'd1, 5'd0, 5'd13, 3'd4);
      e.imm = 64'h400; e.alu_op = 4'b0100; e.src_b = 1'b1; e.reg_write = 1'b1;
      drive("xori", 32'h4000C693, 64'h134, 1'b0, 1'b0, e);
      tick();

      // add x0, x1, x2: valid but no register write
      e = base(64'h138, 5'd1, 5'd2, 5'd0, 3'd0);
      drive("add_x0", 32'h00208033, 64'h138, 1'b0, 1'b0, e);
      tick();

      // unknown opcode vs. fetch reset value
      e = '0; e.illegal = 1'b1;
      drive("illegal", 32'h0000007F, 64'h13C, 1'b0, 1'b0, e);
      tick();
      drive("zero", 32'h00000000, 64'h140, 1'b0, 1'b0, '0);
      tick();

      // flush masks a load-use hazard
      e = base(64'h144, 5'd1, 5'd0, 5'd6, 3'd3);
      e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.src_b = 1'b1;
      drive("ld2", 32'h0000B303, 64'h144, 1'b0, 1'b0, e);
      tick();
      drive("flush_hz", 32'h002303B3, 64'h148, 1'b1, 1'b0, '0);
      cmp("hazard", 64'(hazard_stall), 64'd0);
      tick();

      // asynchronous reset mid-stream with stall_in high
      e.pc = 64'h14C;
      drive("ld3", 32'h0000B303, 64'h14C, 1'b0, 1'b0, e);
      tick();
      cur = "async_reset";
      instruction_IF = 32'h002303B3; stall_in = 1'b1;
      #1;
      cmp("hazard_pre", 64'(hazard_stall), 64'd1);
      reset = 1'b1;
      #1;
      cmp("valid",    64'(valid_ID),     64'd0);
      cmp("pc",       pc_ID,             64'd0);
      cmp("mem_read", 64'(mem_read_ID),  64'd0);
      cmp("rd",       64'(rd_ID),        64'd0);
      cmp("rs1_val",  rs1_val_ID,        64'd0);
      cmp("rw",       64'(reg_write_ID), 64'd0);
      cmp("hazard",   64'(hazard_stall), 64'd0);
      sb_q.delete();
      @(negedge clk);
      reset = 1'b0; stall_in = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
